max_score_tracker: RTL and testbench

// - Downstream of the matrix calculation stage; consumes its registered per-PE score array, one anti-diagonal wave of PUs per cycle.
// - Finds the alignment maximum score and its (row, col) cell coordinate through a 3-stage compare pipeline.
// - Reports the result to the traceback controller with a busy/done handshake.

---
 rtl/max_score_tracker.sv | 222 ++++++++++++++++++++++
 tb/tb_max_score_tracker.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_score_tracker.sv
// max_score_tracker: tracks the best cell score of a wavefront matrix fill
// and its (row, col), then hands the result over with busy/done.
module max_score_tracker #(
  parameter int NUM_PU      = 16,
  parameter int NUM_ROWS_PE = 2,
  parameter int NUM_COLS_PE = 2,
  parameter int SCORE_WIDTH = 8,
  parameter int SEQ_LENGTH  = 32,
  localparam int CW  = $clog2(SEQ_LENGTH),
  localparam int SIW = NUM_PU * NUM_ROWS_PE
                     * NUM_COLS_PE * SCORE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   score_valid,
  input  logic                   score_last,
  input  logic [CW-1:0]          wave,
  input  logic [SIW-1:0]         scores_in,
  output logic                   busy,
  output logic                   done,
  output logic [SCORE_WIDTH-1:0] max_score,
  output logic [CW-1:0]          max_row,
  output logic [CW-1:0]          max_col
);

  localparam int XW = CW + 1;

  typedef logic [NUM_PU-1:0][NUM_ROWS_PE-1:0]
                [NUM_COLS_PE-1:0][SCORE_WIDTH-1:0] sc_arr_t;

  typedef enum logic [1:0] {
    IDLE, ACCUM, DRAIN, DONE
  } state_t;

  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic          p0_vld_q, p0_vld_d;
  logic [CW-1:0] p0_wave_q;
  sc_arr_t       p0_sc_q;
  logic [XW-1:0] w6;

  logic          pu_on [NUM_PU];
  logic [XW-1:0] pu_rb [NUM_PU];
  logic [XW-1:0] pu_cb [NUM_PU];

  logic                   s1_vld_q, s1_vld_d;
  logic [SCORE_WIDTH-1:0] s1_sc_q  [NUM_PU];
  logic [SCORE_WIDTH-1:0] s1_sc_d  [NUM_PU];
  logic [CW-1:0]          s1_row_q [NUM_PU];
  logic [CW-1:0]          s1_row_d [NUM_PU];
  logic [CW-1:0]          s1_col_q [NUM_PU];
  logic [CW-1:0]          s1_col_d [NUM_PU];

  logic [SCORE_WIDTH-1:0] t_sc  [NUM_PU];
  logic [CW-1:0]          t_row [NUM_PU];
  logic [CW-1:0]          t_col [NUM_PU];

  logic                   s2_vld_q, s2_vld_d;
  logic [SCORE_WIDTH-1:0] s2_sc_q, s2_sc_d;
  logic [CW-1:0]          s2_row_q, s2_row_d;
  logic [CW-1:0]          s2_col_q, s2_col_d;

  logic [SCORE_WIDTH-1:0] max_score_q, max_score_d;
  logic [CW-1:0]          max_row_q, max_row_d;
  logic [CW-1:0]          max_col_q, max_col_d;

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign max_score = max_score_q;
  assign max_row   = max_row_q;
  assign max_col   = max_col_q;
  assign w6        = XW'(p0_wave_q);

  // FSM next state; start restarts from any state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = ACCUM;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ACCUM: begin
          if (score_valid && score_last) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
        DRAIN: begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // stage valids: accept only in ACCUM, drop wave 0, flush on start
  always_comb begin
    p0_vld_d = (state_q == ACCUM) && score_valid
             && (wave != '0) && !start;
    s1_vld_d = p0_vld_q && !start;
    s2_vld_d = s1_vld_q && !start;
  end

  // S1: PU placement on the anti-diagonal and best of its PEs
  always_comb begin
    for (int i = 0; i < NUM_PU; i++) begin
      if (w6 <= XW'(NUM_PU)) begin
        pu_on[i] = XW'(i) < w6;
        pu_rb[i] = XW'(i);
        pu_cb[i] = w6 - XW'(i + 1);
      end else begin
        pu_on[i] = (XW'(i) + w6) < XW'(2 * NUM_PU);
        pu_rb[i] = XW'(i) + w6 - XW'(NUM_PU);
        pu_cb[i] = XW'(NUM_PU - 1 - i);
      end
      s1_sc_d[i]  = '0;
      s1_row_d[i] = '0;
      s1_col_d[i] = '0;
      if (pu_on[i]) begin
        s1_sc_d[i]  = p0_sc_q[i][0][0];
        s1_row_d[i] = CW'(pu_rb[i] * XW'(NUM_ROWS_PE));
        s1_col_d[i] = CW'(pu_cb[i] * XW'(NUM_COLS_PE));
        for (int j = 0; j < NUM_ROWS_PE; j++) begin
          for (int k = 0; k < NUM_COLS_PE; k++) begin
            if (p0_sc_q[i][j][k] > s1_sc_d[i]) begin
              s1_sc_d[i]  = p0_sc_q[i][j][k];
              s1_row_d[i] = CW'(pu_rb[i] * XW'(NUM_ROWS_PE)
                               + XW'(j));
              s1_col_d[i] = CW'(pu_cb[i] * XW'(NUM_COLS_PE)
                               + XW'(k));
            end
          end
        end
      end
    end
  end

  // S2: pairwise tree, left (lower PU) kept on ties
  always_comb begin
    for (int i = 0; i < NUM_PU; i++) begin
      t_sc[i]  = s1_sc_q[i];
      t_row[i] = s1_row_q[i];
      t_col[i] = s1_col_q[i];
    end
    for (int s = 1; s < NUM_PU; s = s * 2) begin
      for (int i = 0; i + s < NUM_PU; i = i + 2 * s) begin
        if (t_sc[i + s] > t_sc[i]) begin
          t_sc[i]  = t_sc[i + s];
          t_row[i] = t_row[i + s];
          t_col[i] = t_col[i + s];
        end
      end
    end
    s2_sc_d  = t_sc[0];
    s2_row_d = t_row[0];
    s2_col_d = t_col[0];
  end

  // S3: strict-greater running max so earlier waves keep ties
  always_comb begin
    max_score_d = max_score_q;
    max_row_d   = max_row_q;
    max_col_d   = max_col_q;
    if (start) begin
      max_score_d = '0;
      max_row_d   = '0;
      max_col_d   = '0;
    end else if (s2_vld_q && (s2_sc_q > max_score_q)) begin
      max_score_d = s2_sc_q;
      max_row_d   = s2_row_q;
      max_col_d   = s2_col_q;
    end
  end

  // state, pipeline and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p0_vld_q    <= 1'b0;
      p0_wave_q   <= '0;
      p0_sc_q     <= '0;
      s1_vld_q    <= 1'b0;
      for (int i = 0; i < NUM_PU; i++) begin
        s1_sc_q[i]  <= '0;
        s1_row_q[i] <= '0;
        s1_col_q[i] <= '0;
      end
      s2_vld_q    <= 1'b0;
      s2_sc_q     <= '0;
      s2_row_q    <= '0;
      s2_col_q    <= '0;
      max_score_q <= '0;
      max_row_q   <= '0;
      max_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p0_vld_q    <= p0_vld_d;
      p0_wave_q   <= wave;
      p0_sc_q     <= sc_arr_t'(scores_in);
      s1_vld_q    <= s1_vld_d;
      s1_sc_q     <= s1_sc_d;
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
      s2_vld_q    <= s2_vld_d;
      s2_sc_q     <= s2_sc_d;
      s2_row_q    <= s2_row_d;
      s2_col_q    <= s2_col_d;
      max_score_q <= max_score_d;
      max_row_q   <= max_row_d;
      max_col_q   <= max_col_d;
    end
  end

endmodule

// File: tb/tb_max_score_tracker.sv
// tb_max_score_tracker: table of single-matrix cases plus
// hand sequences for latency, restart in DRAIN and async reset.
module tb_max_score_tracker;

  localparam int SIW = 512;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           score_valid = 1'b0;
  logic           score_last = 1'b0;
  logic [4:0]     wave = '0;
  logic [SIW-1:0] scores_in = '0;
  logic           busy;
  logic           done;
  logic [7:0]     max_score;
  logic [4:0]     max_row;
  logic [4:0]     max_col;

  always #5 clk = ~clk;

  max_score_tracker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .score_valid(score_valid),
    .score_last (score_last),
    .wave       (wave),
    .scores_in  (scores_in),
    .busy       (busy),
    .done       (done),
    .max_score  (max_score),
    .max_row    (max_row),
    .max_col    (max_col)
  );

  typedef struct {
    int es;
    int er;
    int ec;
  } exp_t;

  typedef struct {
    int w1, p1, j1, k1, v1;
    int w2, p2, j2, k2, v2;
    int es, er, ec;
  } vec_t;

  exp_t           sbq[$];
  vec_t           tbl[10];
  logic [SIW-1:0] wv[1:31];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done) begin
      done_cnt++;
      done_cyc = cyc;
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("max_score", int'(max_score), e.es);
        chk("max_row", int'(max_row), e.er);
        chk("max_col", int'(max_col), e.ec);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wv();
    for (int w = 1; w <= 31; w++) wv[w] = '0;
  endtask

  task automatic set_hit(int w, int p, int j, int k, int v);
    if (w != 0) wv[w][((p * 2 + j) * 2 + k) * 8 +: 8] = 8'(v);
  endtask

  task automatic push(int es, int er, int ec);
    exp_t e;
    e.es = es;
    e.er = er;
    e.ec = ec;
    sbq.push_back(e);
  endtask

  // start, 31 waves, expect done exactly 4 cycles after the last
  task automatic run_waves(string nm, int es, int er, int ec,
                           bit lat);
    int last;
    int seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, "_busy_start"}, int'(busy), 1);
    chk({nm, "_max_clr"}, int'(max_score), 0);
    for (int w = 1; w <= 31; w++) begin
      score_valid = 1'b1;
      wave = 5'(w);
      scores_in = wv[w];
      score_last = (w == 31);
      if (w == 31) push(es, er, ec);
      tick();
      if (lat && w >= 5 && w <= 8)
        chk($sformatf("%s_lat%0d", nm, w), int'(max_score),
            (w == 8) ? 'h7f : 0);
    end
    last = cyc;
    score_valid = 1'b0;
    score_last = 1'b0;
    scores_in = '0;
    wave = '0;
    seen = done_cnt;
    for (int n = 0; n < 12 && done_cnt == seen; n++) tick();
    chk({nm, "_done_seen"}, done_cnt - seen, 1);
    if (done_cnt == seen) sbq.delete();
    else chk({nm, "_done_lat"}, done_cyc - last, 4);
    chk({nm, "_busy_end"}, int'(busy), 0);
  endtask

  // random matrix; junk in inactive PUs must be ignored
  task automatic rand_matrix(output int es, output int er,
                             output int ec);
    int v;
    bit on;
    int rb;
    int cb;
    es = 0;
    er = 0;
    ec = 0;
    for (int w = 1; w <= 31; w++) begin
      wv[w] = '0;
      for (int i = 0; i < 16; i++) begin
        on = (w <= 16) ? (i < w) : (i < 32 - w);
        rb = (w <= 16) ? i : i + w - 16;
        cb = (w <= 16) ? w - 1 - i : 15 - i;
        for (int j = 0; j < 2; j++) begin
          for (int k = 0; k < 2; k++) begin
            v = on ? $urandom_range(0, 250) : 255;
            set_hit(w, i, j, k, v);
            if (on && v > es) begin
              es = v;
              er = 2 * rb + j;
              ec = 2 * cb + k;
            end
          end
        end
      end
    end
  endtask

  initial begin
    int es;
    int er;
    int ec;
    int seen;

    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{5, 2, 1, 0, 'h7f, 0, 0, 0, 0, 0, 'h7f, 5, 4};
    tbl[2] = '{20, 3, 0, 1, 'hc8, 20, 2, 1, 1, 'hc7,
               'hc8, 14, 25};
    tbl[3] = '{3, 0, 0, 0, 'h40, 9, 4, 0, 0, 'h40, 'h40, 0, 4};
    tbl[4] = '{2, 5, 1, 1, 'hff, 7, 1, 0, 0, 'h10, 'h10, 2, 10};
    tbl[5] = '{31, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 31, 31};
    tbl[6] = '{16, 15, 1, 0, 'hff, 16, 0, 0, 0, 'hff,
               'hff, 0, 30};
    tbl[7] = '{1, 1, 0, 0, 'hff, 1, 0, 0, 1, 'h80, 'h80, 0, 1};
    tbl[8] = '{4, 1, 1, 0, 'h55, 4, 1, 0, 1, 'h55, 'h55, 2, 5};
    tbl[9] = '{17, 15, 0, 0, 'hee, 17, 14, 1, 1, 'h33,
               'h33, 31, 3};

    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_score", int'(max_score), 0);
    chk("rst_row", int'(max_row), 0);
    chk("rst_col", int'(max_col), 0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 10; t++) begin
      clear_wv();
      set_hit(tbl[t].w1, tbl[t].p1, tbl[t].j1, tbl[t].k1,
              tbl[t].v1);
      set_hit(tbl[t].w2, tbl[t].p2, tbl[t].j2, tbl[t].k2,
              tbl[t].v2);
      run_waves($sformatf("vec%0d", t), tbl[t].es, tbl[t].er,
                tbl[t].ec, 1'b0);
      tick();
    end

    clear_wv();
    set_hit(5, 2, 1, 0, 'h7f);
    run_waves("latency", 'h7f, 5, 4, 1'b1);

    for (int r = 0; r < 3; r++) begin
      rand_matrix(es, er, ec);
      run_waves($sformatf("rand%0d", r), es, er, ec, 1'b0);
    end

    clear_wv();
    set_hit(5, 2, 1, 0, 'h7f);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 1; w <= 31; w++) begin
      score_valid = 1'b1;
      wave = 5'(w);
      scores_in = wv[w];
      score_last = (w == 31);
      tick();
    end
    score_valid = 1'b0;
    score_last = 1'b0;
    scores_in = '0;
    tick();
    tick();
    chk("drain_max_pre", int'(max_score), 'h7f);
    seen = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("drain_busy", int'(busy), 1);
    chk("drain_score", int'(max_score), 0);
    chk("drain_row", int'(max_row), 0);
    chk("drain_col", int'(max_col), 0);
    for (int n = 0; n < 8; n++) tick();
    chk("drain_no_done", done_cnt - seen, 0);
    chk("drain_busy_hold", int'(busy), 1);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 1; w <= 10; w++) begin
      score_valid = 1'b1;
      wave = 5'(w);
      scores_in = wv[w];
      tick();
    end
    score_valid = 1'b0;
    scores_in = '0;
    chk("rstm_pre_score", int'(max_score), 'h7f);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstm_busy", int'(busy), 0);
    chk("rstm_done", int'(done), 0);
    chk("rstm_score", int'(max_score), 0);
    chk("rstm_row", int'(max_row), 0);
    chk("rstm_col", int'(max_col), 0);
    tick();
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    chk("rstm_idle", int'(busy), 0);

    clear_wv();
    set_hit(20, 3, 0, 1, 'hc8);
    run_waves("post_rst", 'hc8, 14, 25, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
